store_aligner_buffer: RTL and testbench
=======================================

Name: store_aligner_buffer

Overview:
- Store-side counterpart of the load data slicer. It accepts store requests (SB/SH/SW) from the execute/memory stage and aligns the write data onto byte lanes.
- It generates the 4-bit byte-enable mask and holds requests in a small in-order FIFO.
- It drives the data-memory write port with a req/ack handshake.
- It sits between the LSU control path and the data memory write interface.

Parameters:
- DEPTH, 2, number of buffered stores; power of 2, minimum 2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept; equals !full; no combinational path from mem_ack.
- st_addr  in  ADDR_W  byte address computed by the ALU.
- st_wdata  in  32  rs2 value, unaligned, in the low bits.
- st_funct3  in  3  store width: FUNCT3_B=000, FUNCT3_H=001, FUNCT3_W=010.
- mem_req  out  1  write request to data memory.
- mem_ack  in  1  memory accepted the current write.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit i enables byte [8i+7:8i].
- misalign  out  1  one-cycle pulse for a rejected misaligned store.
- busy  out  1  high when the FIFO is non-empty; used for load/fence ordering.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_n=0 clears the FIFO pointers and count immediately.
  - Outputs under reset: mem_req=0, misalign=0, busy=0, st_ready=0. mem_addr, mem_wdata and mem_be are 0.
  - st_ready rises the first cycle after reset release.
- Accept: a store is accepted on a rising edge with st_valid & st_ready.
- Alignment (combinational, before enqueue; off = st_addr[1:0]):
  - B: mem_wdata = {4{st_wdata[7:0]}}; mem_be = 4'b0001 << off.
  - H: mem_wdata = {2{st_wdata[15:0]}}; mem_be = off[1] ? 4'b1100 : 4'b0011. Misaligned if off[0]=1.
  - W and any other funct3: mem_wdata = st_wdata; mem_be = 4'b1111. Misaligned if off != 0.
- Enqueue: each entry stores {addr[ADDR_W-1:2], wdata, be}. An accepted, non-misaligned store is visible on the mem_* outputs no earlier than the next cycle.
- Dequeue FSM: states IDLE and REQ.
  - IDLE -> REQ when the FIFO is non-empty. mem_req=1 and mem_* show the head entry.
  - In REQ, mem_req and the mem_* outputs stay stable until mem_ack=1.
  - On ack, the head pops in that cycle. Go to REQ again if entries remain (back-to-back writes, no bubble), else IDLE.
  - mem_ack while mem_req=0 is ignored.
- Simultaneous push and pop:
  - Count is unchanged.
  - With a single entry and a push in the same cycle as the ack, the new entry is presented the next cycle with mem_req held at 1.
- Full: st_ready=0. A push is not accepted even in a cycle where mem_ack pops an entry.
- Order: strictly FIFO. Pointers wrap modulo DEPTH. A count of DEPTH+1 states distinguishes full from empty.
- busy = (count != 0).
- Reset mid-operation: any in-flight write is abandoned and mem_req drops asynchronously. The memory treats a req deassertion before ack as an abort.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned store still completes its handshake (st_ready obeys the full rule).
  - It is not enqueued.
  - misalign pulses high for exactly one cycle, the cycle after acceptance.
- Undefined:
  - Low address bits are forced aligned: H clears off[0]; W clears off[1:0].
  - The store is enqueued normally and misalign is tied to 0.

Decomposition:
- riscv_pkg gains:
  - FUNCT3_B/H/W (if not already present).
  - store_entry_t struct {word_addr, wdata, be}.
  - STORE_BE_W=4.
  - typedef st_state_e {ST_IDLE, ST_REQ}.
- Sub-module store_lane_align: purely combinational. Inputs funct3 and off; outputs wdata, be and misaligned. Kept separate so it can be unit-tested against the load slicer.

Test Plan:
- SB, st_addr=0x1003, st_wdata=0x000000AB, mem_ack=1 on first req -> mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xABABABAB, one mem_req cycle.
- SH, st_addr=0x2002, st_wdata=0xFFFF1234 -> mem_addr=0x2000, mem_be=4'b1100, mem_wdata=0x12341234.
- SW, st_addr=0x3001, st_wdata=0xDEADBEEF:
  - With MISALIGN_TRAP_EN: misalign pulses 1 cycle, mem_req never asserts, busy stays 0.
  - Without it: mem_addr=0x3000, mem_be=4'b1111, mem_wdata=0xDEADBEEF.
- DEPTH=2, mem_ack held low 6 cycles, push SW to 0x10, 0x14, 0x18 -> st_ready=0 after the second accept. Third is accepted after the first ack. Writes emerge in order 0x10, 0x14, 0x18 with mem_* stable while acks are withheld.
- One entry pending, push and mem_ack in the same cycle -> count stays 1, mem_req stays 1, next cycle shows the new entry.
- rst_n low in REQ with 2 entries -> mem_req=0 immediately, busy=0. After release, no stale write appears.

Source files
------------

// File: rtl/store_aligner_buffer_pkg.sv
// Shared types and constants for the store aligner buffer.
// Holds the store funct3 encodings, the buffered entry layout and the
// dequeue FSM state type.
package store_aligner_buffer_pkg;

   localparam logic [2:0] FUNCT3_B = 3'b000;
   localparam logic [2:0] FUNCT3_H = 3'b001;
   localparam logic [2:0] FUNCT3_W = 3'b010;

   localparam int STORE_BE_W = 4;
   localparam int ST_ADDR_W  = 32;
   localparam int ST_WORD_W  = ST_ADDR_W - 2;

   // One buffered store: word address, lane-aligned data and byte enables
   typedef struct packed {
      logic [ST_WORD_W-1:0]  word_addr;
      logic [31:0]           wdata;
      logic [STORE_BE_W-1:0] be;
   } store_entry_t;

   typedef enum logic {
      ST_IDLE,
      ST_REQ
   } st_state_e;

endpackage

// File: rtl/store_aligner_buffer_lane_align.sv
// store_lane_align: combinational byte-lane steering for stores.
// Replicates the narrow store data across all lanes and builds the byte
// enable mask from the low address bits; flags misaligned H/W stores.
module store_lane_align
   import store_aligner_buffer_pkg::*;
(
   input  logic [2:0]            i_funct3,
   input  logic [1:0]            i_off,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_wdata,
   output logic [STORE_BE_W-1:0] o_be,
   output logic                  o_misaligned
);

   // Lane replication and mask per store width; word is the fallback width
   always_comb begin
      o_wdata      = i_wdata;
      o_be         = 4'b1111;
      o_misaligned = 1'b0;
      case (i_funct3)
         FUNCT3_B: begin
            o_wdata = {4{i_wdata[7:0]}};
            o_be    = 4'b0001 << i_off;
         end
         FUNCT3_H: begin
            o_wdata      = {2{i_wdata[15:0]}};
            o_be         = i_off[1] ? 4'b1100 : 4'b0011;
            o_misaligned = i_off[0];
         end
         default: begin
            o_wdata      = i_wdata;
            o_be         = 4'b1111;
            o_misaligned = (i_off != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/store_aligner_buffer.sv
// store_aligner_buffer: aligns SB/SH/SW stores onto byte lanes, queues them
// in an in-order FIFO and drains them to data memory via req/ack.
// Optional macro MISALIGN_TRAP_EN: misaligned stores are dropped and flagged
// with a one-cycle misalign pulse instead of being force-aligned.
module store_aligner_buffer
   import store_aligner_buffer_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_st_valid,
   output logic                  o_st_ready,
   input  logic [ADDR_W-1:0]     i_st_addr,
   input  logic [31:0]           i_st_wdata,
   input  logic [2:0]            i_st_funct3,
   output logic                  o_mem_req,
   input  logic                  i_mem_ack,
   output logic [ADDR_W-1:0]     o_mem_addr,
   output logic [31:0]           o_mem_wdata,
   output logic [STORE_BE_W-1:0] o_mem_be,
   output logic                  o_misalign,
   output logic                  o_busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   store_entry_t          r_fifo [DEPTH];
   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_started;
   st_state_e             r_state;
   logic                  r_memReq;
   store_entry_t          r_memEntry;

   logic [31:0]           w_alignedData;
   logic [STORE_BE_W-1:0] w_alignedBe;
   logic                  w_misaligned;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic [PTR_W-1:0]      w_nextRdPtr;
   store_entry_t          w_newEntry;

   store_lane_align u_laneAlign (
      .i_funct3     (i_st_funct3),
      .i_off        (i_st_addr[1:0]),
      .i_wdata      (i_st_wdata),
      .o_wdata      (w_alignedData),
      .o_be         (w_alignedBe),
      .o_misaligned (w_misaligned)
   );

   // Ready depends only on registered count, never on the memory ack
   assign o_st_ready  = r_started & (r_count != CNT_W'(DEPTH));
   assign w_accept    = i_st_valid & o_st_ready;
   assign w_pop       = r_memReq & i_mem_ack;
   assign w_nextRdPtr = r_rdPtr + PTR_W'(1);
   assign o_busy      = (r_count != '0);
   assign o_mem_req   = r_memReq;
   assign o_mem_addr  = {r_memEntry.word_addr[ADDR_W-3:0], 2'b00};
   assign o_mem_wdata = r_memEntry.wdata;
   assign o_mem_be    = r_memEntry.be;

   // Build the entry that would be enqueued from the current store request
   always_comb begin
      w_newEntry           = '0;
      w_newEntry.word_addr = ST_WORD_W'(i_st_addr[ADDR_W-1:2]);
      w_newEntry.wdata     = w_alignedData;
      w_newEntry.be        = w_alignedBe;
   end

`ifdef MISALIGN_TRAP_EN
   logic r_misalign;

   assign w_push     = w_accept & ~w_misaligned;
   assign o_misalign = r_misalign;

   // Pulse misalign for one cycle after a misaligned store is swallowed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_accept & w_misaligned;
      end
   end
`else
   logic w_unusedMisaligned;

   assign w_push             = w_accept;
   assign o_misalign         = 1'b0;
   assign w_unusedMisaligned = w_misaligned;
`endif

   // FIFO storage carries no reset; validity is tracked by the count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wrPtr] <= w_newEntry;
      end
   end

   // Pointers wrap naturally at DEPTH; count tracks push/pop together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= w_nextRdPtr;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Dequeue FSM presents the head and holds it until acked, chaining
   // directly to the next entry (or a same-cycle push) without a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_memReq   <= 1'b0;
         r_memEntry <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_count != '0) begin
                  r_state    <= ST_REQ;
                  r_memReq   <= 1'b1;
                  r_memEntry <= r_fifo[r_rdPtr];
               end
            end
            ST_REQ: begin
               if (i_mem_ack) begin
                  if (r_count > CNT_W'(1)) begin
                     r_memEntry <= r_fifo[w_nextRdPtr];
                  end else if (w_push) begin
                     r_memEntry <= w_newEntry;
                  end else begin
                     r_state    <= ST_IDLE;
                     r_memReq   <= 1'b0;
                     r_memEntry <= '0;
                  end
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_memReq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_aligner_buffer.sv
// Directed testbench for store_aligner_buffer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_store_aligner_buffer;

   logic        clk;
   logic        rst_n;
   logic        stValid;
   logic        stReady;
   logic [31:0] stAddr;
   logic [31:0] stWdata;
   logic [2:0]  stFunct3;
   logic        memReq;
   logic        memAck;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [3:0]  memBe;
   logic        misalign;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   store_aligner_buffer #(.DEPTH(2), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_st_valid  (stValid),
      .o_st_ready  (stReady),
      .i_st_addr   (stAddr),
      .i_st_wdata  (stWdata),
      .i_st_funct3 (stFunct3),
      .o_mem_req   (memReq),
      .i_mem_ack   (memAck),
      .o_mem_addr  (memAddr),
      .o_mem_wdata (memWdata),
      .o_mem_be    (memBe),
      .o_misalign  (misalign),
      .o_busy      (busy)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against any unexpected hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] funct3);
      stValid  = valid;
      stAddr   = addr;
      stWdata  = wdata;
      stFunct3 = funct3;
   endtask

   task automatic waitReq(input string tag);
      for (int i = 0; i < 10 && memReq !== 1'b1; i++) @(negedge clk);
      checkOutput(tag, {31'd0, memReq}, 32'd1);
   endtask

   // Single store: accept, wait for request, check lanes, ack once
   task automatic singleStore(input string tag, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] funct3,
                              input logic [31:0] expAddr, input logic [31:0] expData,
                              input logic [3:0] expBe);
      applyStimulus(1'b1, addr, wdata, funct3);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 3'b000);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      waitReq({tag, "_req"});
      checkOutput({tag, "_addr"}, memAddr, expAddr);
      checkOutput({tag, "_data"}, memWdata, expData);
      checkOutput({tag, "_be"}, {28'd0, memBe}, {28'd0, expBe});
      memAck = 1'b1;
      @(negedge clk);
      memAck = 1'b0;
      checkOutput({tag, "_reqDrop"}, {31'd0, memReq}, 32'd0);
      checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   // Linear sequence of directed steps
   initial begin
      rst_n  = 1'b0;
      memAck = 1'b0;
      applyStimulus(1'b0, 32'd0, 32'd0, 3'b000);

      // Reset values
      repeat (2) @(negedge clk);
      checkOutput("rst_req", {31'd0, memReq}, 32'd0);
      checkOutput("rst_ready", {31'd0, stReady}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
      checkOutput("rst_addr", memAddr, 32'd0);
      checkOutput("rst_data", memWdata, 32'd0);
      checkOutput("rst_be", {28'd0, memBe}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_rst", {31'd0, stReady}, 32'd1);

      // Byte and half stores on various offsets
      singleStore("sb1003", 32'h0000_1003, 32'h0000_00AB, 3'b000,
                  32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
      singleStore("sb4001", 32'h0000_4001, 32'h1234_5655, 3'b000,
                  32'h0000_4000, 32'h5555_5555, 4'b0010);
      singleStore("sh2002", 32'h0000_2002, 32'hFFFF_1234, 3'b001,
                  32'h0000_2000, 32'h1234_1234, 4'b1100);
      singleStore("sh5000", 32'h0000_5000, 32'h0000_BEEF, 3'b001,
                  32'h0000_5000, 32'hBEEF_BEEF, 4'b0011);

      // Misaligned word store
`ifdef MISALIGN_TRAP_EN
      applyStimulus(1'b1, 32'h0000_3001, 32'hDEAD_BEEF, 3'b010);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 3'b000);
      checkOutput("trap_pulse", {31'd0, misalign}, 32'd1);
      checkOutput("trap_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      checkOutput("trap_pulseEnd", {31'd0, misalign}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("trap_noReq", {31'd0, memReq}, 32'd0);
         @(negedge clk);
      end
`else
      singleStore("sw3001", 32'h0000_3001, 32'hDEAD_BEEF, 3'b010,
                  32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
      checkOutput("sw3001_noPulse", {31'd0, misalign}, 32'd0);
`endif

      // Fill to DEPTH with acks withheld, then drain in order
      applyStimulus(1'b1, 32'h0000_0010, 32'h1111_1111, 3'b010);
      @(negedge clk);
      applyStimulus(1'b1, 32'h0000_0014, 32'h2222_2222, 3'b010);
      @(negedge clk);
      applyStimulus(1'b1, 32'h0000_0018, 32'h3333_3333, 3'b010);
      checkOutput("full_ready", {31'd0, stReady}, 32'd0);
      waitReq("full_req");
      for (int i = 0; i < 4; i++) begin
         checkOutput("full_holdAddr", memAddr, 32'h0000_0010);
         checkOutput("full_holdData", memWdata, 32'h1111_1111);
         checkOutput("full_holdReady", {31'd0, stReady}, 32'd0);
         @(negedge clk);
      end
      memAck = 1'b1;
      @(negedge clk);
      memAck = 1'b0;
      checkOutput("drain2_req", {31'd0, memReq}, 32'd1);
      checkOutput("drain2_addr", memAddr, 32'h0000_0014);
      checkOutput("drain2_data", memWdata, 32'h2222_2222);
      checkOutput("drain2_ready", {31'd0, stReady}, 32'd1);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 3'b000);
      checkOutput("third_acceptFull", {31'd0, stReady}, 32'd0);
      checkOutput("drain2_stable", memAddr, 32'h0000_0014);
      memAck = 1'b1;
      @(negedge clk);
      checkOutput("drain3_req", {31'd0, memReq}, 32'd1);
      checkOutput("drain3_addr", memAddr, 32'h0000_0018);
      checkOutput("drain3_data", memWdata, 32'h3333_3333);
      @(negedge clk);
      memAck = 1'b0;
      checkOutput("drain_done_req", {31'd0, memReq}, 32'd0);
      checkOutput("drain_done_busy", {31'd0, busy}, 32'd0);

      // Push in the same cycle as the ack of the only pending entry
      applyStimulus(1'b1, 32'h0000_0020, 32'hAAAA_0001, 3'b010);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 3'b000);
      waitReq("pp_req");
      checkOutput("pp_firstAddr", memAddr, 32'h0000_0020);
      applyStimulus(1'b1, 32'h0000_0024, 32'hBBBB_0002, 3'b010);
      memAck = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 3'b000);
      memAck = 1'b0;
      checkOutput("pp_reqHeld", {31'd0, memReq}, 32'd1);
      checkOutput("pp_newAddr", memAddr, 32'h0000_0024);
      checkOutput("pp_newData", memWdata, 32'hBBBB_0002);
      checkOutput("pp_busy", {31'd0, busy}, 32'd1);
      checkOutput("pp_ready", {31'd0, stReady}, 32'd1);
      memAck = 1'b1;
      @(negedge clk);
      memAck = 1'b0;
      checkOutput("pp_done", {31'd0, memReq}, 32'd0);

      // Reset in the middle of a request with two entries queued
      applyStimulus(1'b1, 32'h0000_0030, 32'hCCCC_CCCC, 3'b010);
      @(negedge clk);
      applyStimulus(1'b1, 32'h0000_0034, 32'hDDDD_DDDD, 3'b010);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 3'b000);
      waitReq("mid_req");
      checkOutput("mid_addr", memAddr, 32'h0000_0030);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_reqDrop", {31'd0, memReq}, 32'd0);
      checkOutput("mid_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_ready", {31'd0, stReady}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("post_noStale", {31'd0, memReq}, 32'd0);
         checkOutput("post_busy", {31'd0, busy}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
